// File: rtl/mux_pipe_reg.sv
// Registered N-way selector with a valid/ready handshake and a 2-entry skid buffer.
// Optional MUX_PIPE_SEL_CHECK_EN: out-of-range selects capture zero and set sticky sel_err_o.
module mux_pipe_reg #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic [NUM_IN*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]        select_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [WIDTH-1:0]        data_o,
    output logic [SEL_W-1:0]        sel_o,
    output logic                    valid_o,
    input  logic                    ready_i,
`ifdef MUX_PIPE_SEL_CHECK_EN
    output logic                    sel_err_o,
`endif
    output logic [1:0]              occupancy_o
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [SEL_W-1:0] main_sel_q, main_sel_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
    logic [WIDTH-1:0] new_data;
    logic             accept;
    logic             pop;

    assign valid_o     = (state_q != ST_EMPTY);
    assign ready_o     = (state_q != ST_TWO);
    assign occupancy_o = (state_q == ST_TWO) ? 2'd2 :
                         (state_q == ST_ONE) ? 2'd1 : 2'd0;
    assign data_o      = main_data_q;
    assign sel_o       = main_sel_q;

    assign accept = valid_i && ready_o;
    assign pop    = valid_o && ready_i;

    // Out-of-range selects fall through to the default below.
    always_comb begin
`ifdef MUX_PIPE_SEL_CHECK_EN
        new_data = '0;
`else
        new_data = data_i[WIDTH-1:0];
`endif
        for (int unsigned k = 0; k < NUM_IN; k++) begin
            if (select_i == SEL_W'(k)) begin
                new_data = data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_data_d = new_data;
                        main_sel_d  = select_i;
                        state_d     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_data_d = new_data;
                        main_sel_d  = select_i;
                    end else if (accept) begin
                        skid_data_d = new_data;
                        skid_sel_d  = select_i;
                        state_d     = ST_TWO;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (pop) begin
                        main_data_d = skid_data_q;
                        main_sel_d  = skid_sel_q;
                        state_d     = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_EMPTY;
            main_data_q <= '0;
            main_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
        end
    end

`ifdef MUX_PIPE_SEL_CHECK_EN
    logic sel_err_q, sel_err_d;
    logic sel_oob;

    assign sel_oob   = (32'(select_i) >= 32'(NUM_IN));
    // A flushed accept is discarded, so it must not flag an error either.
    assign sel_err_d = sel_err_q | (accept && !flush_i && sel_oob);
    assign sel_err_o = sel_err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end
`endif

endmodule
